// File: rtl/boot_sequencer_if.sv
// Byte-stream, transmit handshake and instruction-memory write bundle of the boot sequencer.
// master = sequencer side, slave = UART/memory side.
interface boot_sequencer_if #(
   parameter int unsigned IMEM_ADDR_W = 12
);
   logic                   rx_valid;
   logic [7:0]             rx_data;
   logic                   tx_valid;
   logic                   tx_ready;
   logic [7:0]             tx_data;
   logic                   imem_we;
   logic [IMEM_ADDR_W-1:0] imem_addr;
   logic [31:0]            imem_wdata;

   modport master (
      input  rx_valid, rx_data, tx_ready,
      output tx_valid, tx_data, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      output rx_valid, rx_data, tx_ready,
      input  tx_valid, tx_data, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/boot_sequencer.sv
// Loads a length-prefixed program from the UART byte stream into instruction memory,
// runs the core until it reports exec-done, then re-arms for the next program.
module boot_sequencer #(
   parameter int unsigned IMEM_ADDR_W = 12,
   parameter logic [7:0]  ACK_BYTE    = 8'hAA,
   parameter logic [7:0]  DONE_BYTE   = 8'h55,
   parameter logic [7:0]  ERR_BYTE    = 8'hEE
) (
   input  logic              clk,
   input  logic              rstn,
   boot_sequencer_if.master  bus,
   output logic              core_gating_signal,
   input  logic              core_exec_done,
   output logic              busy
);

   localparam int unsigned IDX_W     = IMEM_ADDR_W + 1;
   localparam logic [31:0] MAX_WORDS = 32'(64'd1 << IMEM_ADDR_W);

   typedef enum logic [2:0] {S_LEN, S_LOAD, S_ACK, S_RUN, S_FIN, S_ERR} state_t;

   state_t            state;
   logic [1:0]        byte_cnt;
   logic [31:0]       len_q;
   logic [23:0]       word_q;
   logic [IDX_W-1:0]  idx;

   logic [31:0]       len_full;
   logic [31:0]       word_full;
   logic [IDX_W-1:0]  idx_nxt;
   logic              tx_done;

   // The 4th byte completes a value directly from rx_data, so no extra cycle is spent assembling.
   assign len_full  = {bus.rx_data, len_q[23:0]};
   assign word_full = {bus.rx_data, word_q};
   assign idx_nxt   = idx + IDX_W'(1);
   assign tx_done   = bus.tx_valid & bus.tx_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state              <= S_LEN;
         byte_cnt           <= 2'd0;
         len_q              <= 32'd0;
         word_q             <= 24'd0;
         idx                <= '0;
         bus.tx_valid       <= 1'b0;
         bus.tx_data        <= 8'd0;
         bus.imem_we        <= 1'b0;
         bus.imem_addr      <= '0;
         bus.imem_wdata     <= 32'd0;
         core_gating_signal <= 1'b0;
         busy               <= 1'b0;
      end else begin
         bus.imem_we <= 1'b0;
         case (state)
            S_LEN: begin
               if (bus.rx_valid) begin
                  byte_cnt <= byte_cnt + 2'd1;
                  busy     <= 1'b1;
                  if (byte_cnt == 2'd3) begin
                     len_q <= len_full;
                     idx   <= '0;
                     // Full 32-bit compare so oversized headers cannot alias into range.
                     if (len_full == 32'd0 || len_full > MAX_WORDS) begin
                        state        <= S_ERR;
                        bus.tx_valid <= 1'b1;
                        bus.tx_data  <= ERR_BYTE;
                     end else begin
                        state <= S_LOAD;
                     end
                  end else begin
                     len_q[{byte_cnt, 3'b000} +: 8] <= bus.rx_data;
                  end
               end
            end
            S_LOAD: begin
               if (bus.rx_valid) begin
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     bus.imem_we    <= 1'b1;
                     bus.imem_addr  <= idx[IMEM_ADDR_W-1:0];
                     bus.imem_wdata <= word_full;
                     idx            <= idx_nxt;
                     if (32'(idx_nxt) == len_q) begin
                        state        <= S_ACK;
                        bus.tx_valid <= 1'b1;
                        bus.tx_data  <= ACK_BYTE;
                     end
                  end else begin
                     word_q[{byte_cnt, 3'b000} +: 8] <= bus.rx_data;
                  end
               end
            end
            S_ACK: begin
               if (tx_done) begin
                  bus.tx_valid       <= 1'b0;
                  core_gating_signal <= 1'b1;
                  state              <= S_RUN;
               end
            end
            S_RUN: begin
               if (core_exec_done) begin
                  core_gating_signal <= 1'b0;
                  bus.tx_valid       <= 1'b1;
                  bus.tx_data        <= DONE_BYTE;
                  state              <= S_FIN;
               end
            end
            S_FIN, S_ERR: begin
               if (tx_done) begin
                  bus.tx_valid <= 1'b0;
                  byte_cnt     <= 2'd0;
                  idx          <= '0;
                  busy         <= 1'b0;
                  state        <= S_LEN;
               end
            end
            default: state <= S_LEN;
         endcase
      end
   end

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer with a 4-bit instruction address (16-word programs).
module tb_boot_sequencer;

   localparam int unsigned AW = 4;

   logic clk;
   logic rstn;
   logic core_exec_done;
   logic core_gating_signal;
   logic busy;

   int n_asserts;
   int n_fail;
   int we_count;
   int we0;

   boot_sequencer_if #(.IMEM_ADDR_W(AW)) bus ();

   boot_sequencer #(.IMEM_ADDR_W(AW)) dut (
      .clk                (clk),
      .rstn               (rstn),
      .bus                (bus),
      .core_gating_signal (core_gating_signal),
      .core_exec_done     (core_exec_done),
      .busy               (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts cycles with imem_we high, so pulse count also proves single-cycle width.
   initial we_count = 0;
   always @(negedge clk) if (bus.imem_we === 1'b1) we_count = we_count + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts = n_asserts + 1;
      assert (obs === exp) else begin
         n_fail = n_fail + 1;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      tick();
      bus.rx_valid = 1'b0;
   endtask

   task automatic send_len(input logic [31:0] n);
      for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8]);
   endtask

   task automatic send_word(input string tag, input logic [31:0] w, input logic [31:0] a);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
      chk({tag, "_we"}, 32'(bus.imem_we), 32'd1);
      chk({tag, "_addr"}, 32'(bus.imem_addr), a);
      chk({tag, "_wdata"}, bus.imem_wdata, w);
   endtask

   // Waits (bounded) for an offered byte, checks it, then completes the handshake.
   task automatic do_tx(input string tag, input logic [7:0] exp);
      int t;
      t = 0;
      while (bus.tx_valid !== 1'b1 && t < 20) begin
         tick();
         t++;
      end
      chk({tag, "_valid"}, 32'(bus.tx_valid), 32'd1);
      chk({tag, "_data"}, 32'(bus.tx_data), 32'(exp));
      bus.tx_ready = 1'b1;
      tick();
      bus.tx_ready = 1'b0;
      chk({tag, "_valid_fall"}, 32'(bus.tx_valid), 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'd0);
      chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
      chk({tag, "_imem_we"}, 32'(bus.imem_we), 32'd0);
      chk({tag, "_imem_addr"}, 32'(bus.imem_addr), 32'd0);
      chk({tag, "_imem_wdata"}, bus.imem_wdata, 32'd0);
      chk({tag, "_gating"}, 32'(core_gating_signal), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      n_asserts      = 0;
      n_fail         = 0;
      rstn           = 1'b0;
      core_exec_done = 1'b0;
      bus.rx_valid   = 1'b0;
      bus.rx_data    = 8'd0;
      bus.tx_ready   = 1'b0;

      // Reset state
      tick();
      tick();
      chk_all_zero("rst");
      rstn = 1'b1;
      tick();

      // N=2 load at full byte rate
      send_len(32'd2);
      chk("hdr_busy", 32'(busy), 32'd1);
      chk("hdr_no_we", 32'(bus.imem_we), 32'd0);
      we0 = we_count;
      send_word("w0", 32'h11223344, 32'd0);
      send_word("w1", 32'hDEADBEEF, 32'd1);
      chk("ack_gating_low", 32'(core_gating_signal), 32'd0);

      // tx_ready held low for 10 cycles in S_ACK
      for (int i = 0; i < 10; i++) begin
         chk("stall_valid", 32'(bus.tx_valid), 32'd1);
         chk("stall_data", 32'(bus.tx_data), 32'hAA);
         chk("stall_gating", 32'(core_gating_signal), 32'd0);
         tick();
      end
      chk("n2_we_pulses", 32'(we_count - we0), 32'd2);
      bus.tx_ready = 1'b1;
      tick();
      bus.tx_ready = 1'b0;
      chk("run_gating", 32'(core_gating_signal), 32'd1);
      chk("run_tx_valid", 32'(bus.tx_valid), 32'd0);

      // rx bytes during S_RUN are dropped
      we0 = we_count;
      for (int i = 1; i <= 5; i++) send_byte(8'(i));
      tick();
      chk("run_rx_no_we", 32'(we_count - we0), 32'd0);
      chk("run_rx_gating", 32'(core_gating_signal), 32'd1);
      chk("run_rx_busy", 32'(busy), 32'd1);

      // One-cycle exec-done pulse
      core_exec_done = 1'b1;
      tick();
      core_exec_done = 1'b0;
      chk("fin_gating", 32'(core_gating_signal), 32'd0);
      do_tx("done0", 8'h55);
      chk("rearm_busy", 32'(busy), 32'd0);

      // N=1 load; exec_done high already in S_ACK has no effect, then 1-cycle run
      send_len(32'd1);
      send_word("n1", 32'h00000013, 32'd0);
      core_exec_done = 1'b1;
      tick();
      tick();
      chk("done_in_ack_data", 32'(bus.tx_data), 32'hAA);
      chk("done_in_ack_gating", 32'(core_gating_signal), 32'd0);
      bus.tx_ready = 1'b1;
      tick();
      bus.tx_ready = 1'b0;
      chk("short_run_on", 32'(core_gating_signal), 32'd1);
      tick();
      core_exec_done = 1'b0;
      chk("short_run_off", 32'(core_gating_signal), 32'd0);
      do_tx("done1", 8'h55);

      // Rejected headers: 0, 17, and 0x110 (low bits alias to 16)
      we0 = we_count;
      send_len(32'd0);
      chk("n0_gating", 32'(core_gating_signal), 32'd0);
      do_tx("err0", 8'hEE);
      send_len(32'd17);
      do_tx("err17", 8'hEE);
      send_len(32'h00000110);
      do_tx("err110", 8'hEE);
      tick();
      chk("err_no_we", 32'(we_count - we0), 32'd0);
      chk("err_gating", 32'(core_gating_signal), 32'd0);
      chk("err_busy", 32'(busy), 32'd0);

      // N=16 fills the whole memory
      we0 = we_count;
      send_len(32'd16);
      for (int i = 0; i < 16; i++)
         send_word("n16", 32'h10000000 + 32'(i) * 32'h00010203, 32'(i));
      do_tx("ack16", 8'hAA);
      chk("n16_gating", 32'(core_gating_signal), 32'd1);
      chk("n16_we_pulses", 32'(we_count - we0), 32'd16);
      core_exec_done = 1'b1;
      tick();
      core_exec_done = 1'b0;
      do_tx("done16", 8'h55);

      // Asynchronous reset after 6 bytes of a load
      send_len(32'd1);
      send_byte(8'h11);
      send_byte(8'h22);
      #2;
      rstn = 1'b0;
      #1;
      chk_all_zero("midrst");
      tick();
      tick();
      rstn = 1'b1;
      tick();
      send_len(32'd1);
      send_word("post_rst", 32'hCAFEF00D, 32'd0);
      do_tx("ack_post", 8'hAA);
      chk("post_gating", 32'(core_gating_signal), 32'd1);
      core_exec_done = 1'b1;
      tick();
      core_exec_done = 1'b0;
      do_tx("done_post", 8'h55);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
